// File: rtl/cnn_pkg.sv
// Shared constants and types for the 5x5 convolution window MAC.
package cnn_pkg;

  localparam int DATA_W    = 16;
  localparam int K         = 5;
  localparam int WIN_SIZE  = K * K;
  localparam int FRAC      = 8;
  localparam int ADDR_W    = 5;
  // Row sum of K full-width products needs 3 guard bits (K <= 8).
  localparam int ROW_SUM_W = 2 * DATA_W + 3;

  localparam logic [ADDR_W-1:0] WT_BIAS_ADDR = 5'd25;

  // Result clamp limits (signed DATA_W range).
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    RND  = 2'd2,
    OUT  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/conv_window_mac_if.sv
// Window / weight / result bus of the convolution window MAC.
interface conv_window_mac_if;
  import cnn_pkg::*;

  logic                               win_valid;
  logic                               win_ready;
  logic [WIN_SIZE-1:0][DATA_W-1:0]    win_data;
  logic                               wt_we;
  logic [ADDR_W-1:0]                  wt_addr;
  logic [DATA_W-1:0]                  wt_data;
  logic                               wt_err;
  logic                               res_valid;
  logic                               res_ready;
  logic [DATA_W-1:0]                  res_data;
  logic                               busy;

  // The MAC block side.
  modport slave (
    input  win_valid, win_data, wt_we, wt_addr, wt_data, res_ready,
    output win_ready, wt_err, res_valid, res_data, busy
  );

  // The producer/consumer side.
  modport master (
    output win_valid, win_data, wt_we, wt_addr, wt_data, res_ready,
    input  win_ready, wt_err, res_valid, res_data, busy
  );

endinterface

// File: rtl/row_dot5.sv
// Combinational dot product of one kernel row: K signed multiplies + adder tree.
module row_dot5
  import cnn_pkg::*;
(
  input  logic [K-1:0][DATA_W-1:0]     i_x,
  input  logic [K-1:0][DATA_W-1:0]     i_w,
  output logic signed [ROW_SUM_W-1:0]  o_sum
);

  logic signed [2*DATA_W-1:0]  w_prod [K];
  logic signed [ROW_SUM_W-1:0] w_ext  [K];
  logic signed [ROW_SUM_W-1:0] w_s01;
  logic signed [ROW_SUM_W-1:0] w_s23;

  // Full-precision products, sign-extended to the row-sum width.
  for (genvar gi = 0; gi < K; gi++) begin : g_lane
    assign w_prod[gi] = $signed(i_x[gi]) * $signed(i_w[gi]);
    assign w_ext[gi]  = {{(ROW_SUM_W-2*DATA_W){w_prod[gi][2*DATA_W-1]}}, w_prod[gi]};
  end

  // Balanced tree for five lanes: (0+1) + (2+3) + 4.
  assign w_s01 = w_ext[0] + w_ext[1];
  assign w_s23 = w_ext[2] + w_ext[3];
  assign o_sum = w_s01 + w_s23 + w_ext[4];

endmodule

// File: rtl/conv_window_mac.sv
// 5x5 window times stored kernel plus bias, rounded/saturated to Q7.8.
// One kernel row per cycle through row_dot5; ready/valid on both sides.
module conv_window_mac
  import cnn_pkg::*;
#(
  parameter int ACC_W   = 40,
  parameter bit RELU_EN = 1'b0
) (
  input  logic             clk,
  input  logic             nrst,
  conv_window_mac_if.slave bus
);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(SAT_MIN);

  mac_state_t                        r_state;
  logic [2:0]                        r_row_cnt;
  logic [WIN_SIZE-1:0][DATA_W-1:0]   r_win;
  logic [WIN_SIZE-1:0][DATA_W-1:0]   r_wt;
  logic [DATA_W-1:0]                 r_bias;
  logic signed [ACC_W-1:0]           r_acc;
  logic                              r_res_valid;
  logic [DATA_W-1:0]                 r_res_data;
  logic                              r_wt_err;

  logic [4:0]                        w_row_base;
  logic [K-1:0][DATA_W-1:0]          w_row_x;
  logic [K-1:0][DATA_W-1:0]          w_row_w;
  logic signed [ROW_SUM_W-1:0]       w_row_sum;
  logic signed [ACC_W-1:0]           w_row_ext;
  logic signed [ACC_W-1:0]           w_bias_sh;
  logic signed [ACC_W-1:0]           w_t;
  logic signed [ACC_W-1:0]           w_r;
  logic [DATA_W-1:0]                 w_sat;
  logic                              w_accept;

  // Select the current kernel row out of the captured window and weights.
  assign w_row_base = 5'(r_row_cnt) * 5'(K);
  for (genvar gi = 0; gi < K; gi++) begin : g_row_sel
    assign w_row_x[gi] = r_win[w_row_base + 5'(gi)];
    assign w_row_w[gi] = r_wt[w_row_base + 5'(gi)];
  end

  row_dot5 u_row_dot5 (
    .i_x   (w_row_x),
    .i_w   (w_row_w),
    .o_sum (w_row_sum)
  );

  assign w_row_ext = {{(ACC_W-ROW_SUM_W){w_row_sum[ROW_SUM_W-1]}}, w_row_sum};

  // Bias is in the same Q format as the result, so it is aligned to the
  // product scale (2*FRAC fraction bits) before rounding.
  assign w_bias_sh = {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias} <<< FRAC;
  assign w_t       = r_acc + w_bias_sh + RND_HALF;
  assign w_r       = w_t >>> FRAC;

  // Clamp to the signed result range, then optional ReLU.
  always_comb begin
    w_sat = w_r[DATA_W-1:0];
    if (w_r > SAT_HI) begin
      w_sat = DATA_W'(SAT_MAX);
    end else if (w_r < SAT_LO) begin
      w_sat = DATA_W'(SAT_MIN);
    end
    if (RELU_EN && w_r[ACC_W-1]) begin
      w_sat = '0;
    end
  end

  // In OUT the next window can be taken on the same edge as the handoff.
  assign bus.win_ready = (r_state == IDLE) || ((r_state == OUT) && bus.res_ready);
  assign w_accept      = bus.win_valid && bus.win_ready;
  assign bus.busy      = (r_state != IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.wt_err    = r_wt_err;

  // Weight/bias file: writes land only while idle; anything else is flagged.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wt     <= '0;
      r_bias   <= '0;
      r_wt_err <= 1'b0;
    end else if (bus.wt_we) begin
      if (r_state == IDLE) begin
        if (bus.wt_addr < WT_BIAS_ADDR) begin
          r_wt[bus.wt_addr] <= bus.wt_data;
        end else if (bus.wt_addr == WT_BIAS_ADDR) begin
          r_bias <= bus.wt_data;
        end
      end else begin
        r_wt_err <= 1'b1;
      end
    end
  end

  // Control FSM: capture window, accumulate K rows, round, hold result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_row_cnt   <= '0;
      r_win       <= '0;
      r_acc       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_win     <= bus.win_data;
            r_acc     <= '0;
            r_row_cnt <= '0;
            r_state   <= MAC;
          end
        end
        MAC: begin
          r_acc     <= r_acc + w_row_ext;
          r_row_cnt <= r_row_cnt + 3'd1;
          if (r_row_cnt == 3'(K - 1)) begin
            r_state <= RND;
          end
        end
        RND: begin
          r_res_data  <= w_sat;
          r_res_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            if (w_accept) begin
              r_win     <= bus.win_data;
              r_acc     <= '0;
              r_row_cnt <= '0;
              r_state   <= MAC;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
